// File: rtl/psum_accum_ctrl_if.sv
// psum_accum_ctrl_if: groups the configuration, result handshake, PSUM SRAM
// and final-sum bus signals of psum_accum_ctrl.
//   master modport : environment side (drives cfg_*, res_valid/res_data,
//                    sram_rd_data; observes everything else)
//   slave modport  : controller side (psum_accum_ctrl)
// Parameters LANES / DATA_W / ADR_W must match the controller instance.
interface psum_accum_ctrl_if #(
    parameter int unsigned LANES  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADR_W  = 11
);
    logic                      cfg_valid;
    logic [ADR_W:0]            cfg_nb_elem;
    logic                      cfg_first_ch;
    logic                      cfg_last_ch;
    logic                      res_valid;
    logic                      res_ready;
    logic [LANES*DATA_W-1:0]   res_data;
    logic                      sram_rd_en;
    logic [ADR_W-1:0]          sram_rd_addr;
    logic [LANES*DATA_W-1:0]   sram_rd_data;
    logic                      sram_wr_en;
    logic [ADR_W-1:0]          sram_wr_addr;
    logic [LANES*DATA_W-1:0]   sram_wr_data;
    logic                      out_valid;
    logic [LANES*DATA_W-1:0]   out_data;
    logic                      busy;
    logic                      done;

    modport master (
        output cfg_valid, cfg_nb_elem, cfg_first_ch, cfg_last_ch,
        output res_valid, res_data, sram_rd_data,
        input  res_ready, sram_rd_en, sram_rd_addr,
        input  sram_wr_en, sram_wr_addr, sram_wr_data,
        input  out_valid, out_data, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_nb_elem, cfg_first_ch, cfg_last_ch,
        input  res_valid, res_data, sram_rd_data,
        output res_ready, sram_rd_en, sram_rd_addr,
        output sram_wr_en, sram_wr_addr, sram_wr_data,
        output out_valid, out_data, busy, done
    );
endinterface

// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: partial-sum accumulator controller between the PE array
// result bus and the PSUM SRAM bank. Each pass does a read-modify-write of
// LANES partial sums for cfg_nb_elem pixels: overwrite on the first input
// channel, accumulate otherwise, and stream final sums on out_* for the last
// channel.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset
//   bus  - psum_accum_ctrl_if.slave: cfg_*, res_* handshake, sram_rd_*,
//          sram_wr_*, out_*, busy, done
// Parameters: LANES, DATA_W, ADR_W, RD_LAT (SRAM read latency, 1..4).
// Optional macro PSUM_ACCUM_SATURATE_EN: saturating per-lane accumulation
// instead of two's-complement wrap-around.
module psum_accum_ctrl #(
    parameter int unsigned LANES  = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADR_W  = 11,
    parameter int unsigned RD_LAT = 1
) (
    input logic               clk,
    input logic               rstn,
    psum_accum_ctrl_if.slave  bus
);
    localparam int unsigned W = LANES * DATA_W;
    localparam logic [ADR_W:0] CNT_ONE = (ADR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADR_W:0]    nb_elem_r;
    logic [ADR_W:0]    in_cnt;
    logic              first_ch_r;
    logic              last_ch_r;
    logic              res_ready_r;
    logic              busy_r;
    logic              done_r;

    logic [RD_LAT-1:0] vld;
    logic [W-1:0]      dline [RD_LAT];
    logic [ADR_W-1:0]  aline [RD_LAT];

    logic              accept;
    logic              last_beat;
    logic              pending;
    logic [W-1:0]      sum;
    logic [DATA_W-1:0] lane_r;
    logic [DATA_W-1:0] lane_m;
    logic [DATA_W-1:0] lane_s;

    assign accept    = bus.res_valid & res_ready_r;
    // in_cnt is one bit wider than the address so a full-depth pass
    // (nb_elem = 2^ADR_W) terminates before the counter wraps.
    assign last_beat = (in_cnt == nb_elem_r - CNT_ONE);

    // Beats still short of the final stage. The last stage is being written
    // this cycle, so once nothing is behind it the line is empty next cycle.
    always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
            pending = pending | vld[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            nb_elem_r   <= '0;
            in_cnt      <= '0;
            first_ch_r  <= 1'b0;
            last_ch_r   <= 1'b0;
            res_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        nb_elem_r  <= bus.cfg_nb_elem;
                        first_ch_r <= bus.cfg_first_ch;
                        last_ch_r  <= bus.cfg_last_ch;
                        in_cnt     <= '0;
                        busy_r     <= 1'b1;
                        if (bus.cfg_nb_elem == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end else begin
                            state       <= RUN;
                            res_ready_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        in_cnt <= in_cnt + CNT_ONE;
                        if (last_beat) begin
                            res_ready_r <= 1'b0;
                            state       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay line aligning beat data/address with the SRAM read return.
    // Overwrite passes use it too so write timing is the same for all passes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                dline[i] <= '0;
                aline[i] <= '0;
            end
        end else begin
            vld[0] <= accept;
            if (accept) begin
                dline[0] <= bus.res_data;
                aline[0] <= in_cnt[ADR_W-1:0];
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld[i]   <= vld[i-1];
                dline[i] <= dline[i-1];
                aline[i] <= aline[i-1];
            end
        end
    end

    always_comb begin
        sum    = '0;
        lane_r = '0;
        lane_m = '0;
        lane_s = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_r = dline[RD_LAT-1][l*DATA_W +: DATA_W];
            lane_m = bus.sram_rd_data[l*DATA_W +: DATA_W];
            if (first_ch_r) begin
                lane_s = lane_r;
            end else begin
                lane_s = lane_r + lane_m;
`ifdef PSUM_ACCUM_SATURATE_EN
                // Overflow only when both operands share a sign the sum lacks.
                if ((lane_r[DATA_W-1] == lane_m[DATA_W-1]) &&
                    (lane_s[DATA_W-1] != lane_r[DATA_W-1])) begin
                    lane_s = lane_r[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                              : {1'b0, {(DATA_W-1){1'b1}}};
                end
`endif
            end
            sum[l*DATA_W +: DATA_W] = lane_s;
        end
    end

    assign bus.res_ready    = res_ready_r;
    assign bus.sram_rd_en   = accept & ~first_ch_r;
    assign bus.sram_rd_addr = in_cnt[ADR_W-1:0];
    assign bus.sram_wr_en   = vld[RD_LAT-1];
    assign bus.sram_wr_addr = aline[RD_LAT-1];
    // Data buses are zeroed outside write slots so reset clears them even
    // while the SRAM read port returns arbitrary data.
    assign bus.sram_wr_data = vld[RD_LAT-1] ? sum : '0;
    assign bus.out_valid    = vld[RD_LAT-1] & last_ch_r;
    assign bus.out_data     = (vld[RD_LAT-1] & last_ch_r) ? sum : '0;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb_psum_accum_ctrl: self-checking bench for psum_accum_ctrl with a
// behavioural PSUM SRAM and a per-pass reference of expected reads, writes,
// final sums and done timing. Honours PSUM_ACCUM_SATURATE_EN when defined.
module tb_psum_accum_ctrl;
    localparam int unsigned LANES  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADR_W  = 4;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned W      = LANES * DATA_W;
    localparam int unsigned DEPTH  = 1 << ADR_W;
    localparam int unsigned CW     = W + 64;
    localparam longint MAXV = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DATA_W - 1));

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    psum_accum_ctrl_if #(.LANES(LANES), .DATA_W(DATA_W), .ADR_W(ADR_W)) bus ();

    psum_accum_ctrl #(
        .LANES(LANES), .DATA_W(DATA_W), .ADR_W(ADR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] junk();
        logic [W-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*DATA_W +: DATA_W] = DATA_W'($urandom);
        return r;
    endfunction

    // Behavioural SRAM: read data appears RD_LAT cycles after the strobe,
    // arbitrary data otherwise.
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdq [RD_LAT];
    always @(posedge clk) begin
        if (bus.sram_wr_en) mem[bus.sram_wr_addr] <= bus.sram_wr_data;
        rdq[0] <= bus.sram_rd_en ? mem[bus.sram_rd_addr] : junk();
        for (int i = 1; i < RD_LAT; i++) rdq[i] <= rdq[i-1];
    end
    assign bus.sram_rd_data = rdq[RD_LAT-1];

    typedef struct {
        int           c;
        int           addr;
        logic [W-1:0] data;
    } ev_t;

    ev_t wr_q[$];
    ev_t rd_q[$];
    ev_t out_q[$];
    int  done_q[$];

    always @(negedge clk) begin
        if (bus.sram_wr_en) wr_q.push_back('{cyc, int'(bus.sram_wr_addr), bus.sram_wr_data});
        if (bus.sram_rd_en) rd_q.push_back('{cyc, int'(bus.sram_rd_addr), '0});
        if (bus.out_valid)  out_q.push_back('{cyc, 0, bus.out_data});
        if (bus.done)       done_q.push_back(cyc);
    end

    logic [W-1:0] ref_mem [DEPTH];
    logic [W-1:0] beat_buf [DEPTH];
    int           acc_cyc [DEPTH];

    function automatic logic [W-1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic signed [DATA_W-1:0] x, y;
        longint s;
        for (int l = 0; l < LANES; l++) begin
            x = a[l*DATA_W +: DATA_W];
            y = b[l*DATA_W +: DATA_W];
            s = longint'(x) + longint'(y);
`ifdef PSUM_ACCUM_SATURATE_EN
            if (s > MAXV) s = MAXV;
            else if (s < MINV) s = MINV;
`endif
            r[l*DATA_W +: DATA_W] = s[DATA_W-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " res_ready"}, CW'(bus.res_ready), '0);
        chk({tag, " rd_en"},     CW'(bus.sram_rd_en), '0);
        chk({tag, " rd_addr"},   CW'(bus.sram_rd_addr), '0);
        chk({tag, " wr_en"},     CW'(bus.sram_wr_en), '0);
        chk({tag, " wr_addr"},   CW'(bus.sram_wr_addr), '0);
        chk({tag, " wr_data"},   CW'(bus.sram_wr_data), '0);
        chk({tag, " out_valid"}, CW'(bus.out_valid), '0);
        chk({tag, " out_data"},  CW'(bus.out_data), '0);
        chk({tag, " busy"},      CW'(bus.busy), '0);
        chk({tag, " done"},      CW'(bus.done), '0);
    endtask

    // gaps: 0 = continuous, 1 = 1,0,1,1,0,1 pattern, 2 = random bubbles
    task automatic run_pass(input int nb, input bit first, input bit last,
                            input int gaps, input bit spurious, input string tag);
        int k, slot, t, c0, nrd, nout;
        bit v;
        logic [5:0] pat;
        logic [W-1:0] expd [DEPTH];
        pat = 6'b101101;
        wr_q.delete(); rd_q.delete(); out_q.delete(); done_q.delete();
        tick();
        bus.cfg_valid    = 1'b1;
        bus.cfg_nb_elem  = (ADR_W + 1)'(nb);
        bus.cfg_first_ch = first;
        bus.cfg_last_ch  = last;
        c0 = cyc;
        tick();
        bus.cfg_valid    = 1'b0;
        bus.cfg_nb_elem  = (ADR_W + 1)'($urandom);
        bus.cfg_first_ch = ~first;
        bus.cfg_last_ch  = ~last;
        if (nb > 0) begin
            chk({tag, " busy in run"}, CW'(bus.busy), CW'(1));
            chk({tag, " ready in run"}, CW'(bus.res_ready), CW'(1));
        end
        k = 0; slot = 0; t = 0;
        while (k < nb && t < 400) begin
            case (gaps)
                0:       v = 1'b1;
                1:       v = pat[slot % 6];
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.res_valid = v;
            bus.res_data  = v ? beat_buf[k] : junk();
            if (spurious && k == 1) begin
                bus.cfg_valid   = 1'b1;
                bus.cfg_nb_elem = (ADR_W + 1)'(1);
            end else begin
                bus.cfg_valid = 1'b0;
            end
            if (v && bus.res_ready) begin
                acc_cyc[k] = cyc;
                k++;
            end
            slot++; t++;
            tick();
        end
        chk({tag, " beats accepted"}, CW'(k), CW'(nb));
        bus.cfg_valid = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_data  = junk();
        chk({tag, " ready low after last"}, CW'(bus.res_ready), '0);
        tick();
        bus.res_valid = 1'b0;
        t = 0;
        while (done_q.size() == 0 && t < 100) begin
            tick();
            t++;
        end
        chk({tag, " busy after done"}, CW'(bus.busy), '0);
        chk({tag, " done one cycle"}, CW'(bus.done), '0);

        for (int i = 0; i < nb; i++) begin
            expd[i] = first ? beat_buf[i] : model_add(ref_mem[i], beat_buf[i]);
        end
        chk({tag, " write count"}, CW'(wr_q.size()), CW'(nb));
        for (int i = 0; i < nb && i < wr_q.size(); i++) begin
            chk($sformatf("%s write %0d", tag, i),
                {32'(wr_q[i].c), 32'(wr_q[i].addr), wr_q[i].data},
                {32'(acc_cyc[i] + RD_LAT), 32'(i), expd[i]});
        end
        nrd = first ? 0 : nb;
        chk({tag, " read count"}, CW'(rd_q.size()), CW'(nrd));
        for (int i = 0; i < nrd && i < rd_q.size(); i++) begin
            chk($sformatf("%s read %0d", tag, i),
                CW'({32'(rd_q[i].c), 32'(rd_q[i].addr)}),
                CW'({32'(acc_cyc[i]), 32'(i)}));
        end
        nout = last ? nb : 0;
        chk({tag, " out count"}, CW'(out_q.size()), CW'(nout));
        for (int i = 0; i < nout && i < out_q.size(); i++) begin
            chk($sformatf("%s out %0d", tag, i),
                {32'(out_q[i].c), 32'(0), out_q[i].data},
                {32'(acc_cyc[i] + RD_LAT), 32'(0), expd[i]});
        end
        chk({tag, " done count"}, CW'(done_q.size()), CW'(1));
        if (done_q.size() > 0) begin
            chk({tag, " done cycle"}, CW'(done_q[0]),
                CW'(nb == 0 ? c0 + 1 : acc_cyc[nb-1] + RD_LAT + 1));
        end
        for (int i = 0; i < nb; i++) ref_mem[i] = expd[i];
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) beat_buf[i] = junk();
    endtask

    initial begin
        logic [W-1:0] d;
        int nb, k, t;
        bit first, last;

        bus.cfg_valid    = 1'b1;
        bus.cfg_nb_elem  = (ADR_W + 1)'(3);
        bus.cfg_first_ch = 1'b1;
        bus.cfg_last_ch  = 1'b1;
        bus.res_valid    = 1'b1;
        bus.res_data     = junk();
        repeat (3) tick();
        check_zero("reset");
        bus.cfg_valid = 1'b0;
        bus.res_valid = 1'b0;
        rstn = 1'b1;
        tick();

        for (int b = 0; b < 4; b++)
            for (int l = 0; l < LANES; l++)
                beat_buf[b][l*DATA_W +: DATA_W] = DATA_W'(b * 100 + l);
        run_pass(4, 1'b1, 1'b0, 0, 1'b0, "overwrite");
        run_pass(4, 1'b0, 1'b0, 0, 1'b0, "accumulate");

        fill_random(4);
        run_pass(4, 1'b0, 1'b1, 1, 1'b0, "lastch gaps");

        run_pass(0, 1'b0, 1'b0, 0, 1'b0, "empty");

        fill_random(5);
        run_pass(5, 1'b1, 1'b0, 0, 1'b1, "cfg during run");

        for (int l = 0; l < LANES; l++)
            beat_buf[0][l*DATA_W +: DATA_W] = (l % 2 == 0) ? 32'h7FFF_FFF0 : 32'h8000_0005;
        run_pass(1, 1'b1, 1'b0, 0, 1'b0, "ovf init");
        for (int l = 0; l < LANES; l++)
            beat_buf[0][l*DATA_W +: DATA_W] = (l % 2 == 0) ? 32'h0000_0020 : 32'hFFFF_FFF0;
        run_pass(1, 1'b0, 1'b1, 0, 1'b0, "ovf");
        d = (wr_q.size() > 0) ? wr_q[0].data : '0;
`ifdef PSUM_ACCUM_SATURATE_EN
        chk("ovf lane0 const", CW'(d[31:0]), CW'(32'h7FFF_FFFF));
        chk("ovf lane1 const", CW'(d[63:32]), CW'(32'h8000_0000));
`else
        chk("ovf lane0 const", CW'(d[31:0]), CW'(32'h8000_0010));
        chk("ovf lane1 const", CW'(d[63:32]), CW'(32'h7FFF_FFF5));
`endif

        fill_random(DEPTH);
        run_pass(DEPTH, 1'b1, 1'b0, 2, 1'b0, "full depth");
        repeat (6) begin
            nb    = $urandom_range(1, DEPTH);
            first = 1'($urandom_range(0, 1));
            last  = 1'($urandom_range(0, 1));
            fill_random(nb);
            run_pass(nb, first, last, 2, 1'b0, "random");
        end

        // Reset after the 2nd of 8 beats of an accumulate/last pass.
        tick();
        bus.cfg_valid    = 1'b1;
        bus.cfg_nb_elem  = (ADR_W + 1)'(8);
        bus.cfg_first_ch = 1'b0;
        bus.cfg_last_ch  = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        k = 0; t = 0;
        while (k < 2 && t < 50) begin
            bus.res_valid = 1'b1;
            bus.res_data  = junk();
            if (bus.res_ready) k++;
            t++;
            tick();
        end
        chk("midreset beats", CW'(k), CW'(2));
        wr_q.delete(); rd_q.delete(); out_q.delete(); done_q.delete();
        #2 rstn = 1'b0;
        #1 check_zero("midreset async");
        repeat (2) tick();
        check_zero("midreset held");
        bus.res_valid = 1'b0;
        rstn = 1'b1;
        repeat (8) tick();
        chk("post reset busy", CW'(bus.busy), '0);
        chk("post reset writes", CW'(wr_q.size()), '0);
        chk("post reset outs", CW'(out_q.size()), '0);
        chk("post reset done", CW'(done_q.size()), '0);

        fill_random(DEPTH);
        run_pass(DEPTH, 1'b1, 1'b1, 0, 1'b0, "recover overwrite");
        fill_random(4);
        run_pass(4, 1'b0, 1'b1, 2, 1'b0, "recover accumulate");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
